// File: rtl/bcd_pkg.sv
// Shared types and constants for the packed-BCD to binary converter.
// Holds the controller state encoding and the output-width helper.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  localparam int BCD_MAX = 9;
  localparam int RADIX   = 10;

  // Number of bits needed to hold RADIX**digits - 1 without wrapping.
  function automatic int digits_to_width(input int digits);
    longint span;
    int     w;
    span = 1;
    for (int i = 0; i < digits; i++) begin
      span = span * RADIX;
    end
    w = 0;
    for (int b = 0; b < 63; b++) begin
      if ((64'd1 << b) < span) begin
        w = b + 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/bcd_mac.sv
// Combinational multiply-by-ten-and-add step: result = acc*10 + digit.
// Implemented as (acc<<3) + (acc<<1) + digit, truncated to WIDTH bits.
module bcd_mac #(
  parameter int WIDTH = 14
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [3:0]       digit,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] times8;
  logic [WIDTH-1:0] times2;
  logic [WIDTH-1:0] digit_ext;

  always_comb begin
    times8    = acc << 3;
    times2    = acc << 1;
    digit_ext = WIDTH'(digit);
    result    = times8 + times2 + digit_ext;
  end

endmodule

// File: rtl/bcd2b_ip.sv
// Packed-BCD to unsigned binary converter, one digit per cycle, MSD first.
// Valid/ready on both sides; result and error flag are held until taken.
module bcd2b_ip
  import bcd_pkg::*;
#(
  parameter int DIGIT = 4,
  parameter int WIDTH = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DIGIT*4-1:0] BCD_code,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   Binary_code,
  output logic               err
);

  localparam int BITS  = DIGIT * 4;
  localparam int CNT_W = (DIGIT > 1) ? $clog2(DIGIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGIT - 1);

  if (DIGIT < 1) begin : g_digit_check
    $error("bcd2b_ip: DIGIT must be at least 1");
  end
  if (WIDTH < digits_to_width(DIGIT)) begin : g_width_check
    $warning("bcd2b_ip: WIDTH too small, results wrap modulo 2**WIDTH");
  end

  state_t           state_reg;
  state_t           state_next;
  logic [BITS-1:0]  shift_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             err_reg;
  logic [WIDTH-1:0] binary_reg;
  logic             err_out_reg;

  logic             load;
  logic             step;
  logic             last_digit;
  logic [3:0]       digit;
  logic             digit_bad;
  logic [WIDTH-1:0] mac_result;

  assign digit      = shift_reg[BITS-1 -: 4];
  assign digit_bad  = (digit > 4'(BCD_MAX));
  assign last_digit = (cnt_reg == LAST_CNT);

  bcd_mac #(
    .WIDTH (WIDTH)
  ) u_mac (
    .acc    (acc_reg),
    .digit  (digit),
    .result (mac_result)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    unique case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load       = 1'b1;
          state_next = CONV;
        end
      end
      CONV: begin
        step = 1'b1;
        if (last_digit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Nibbles above nine still feed the arithmetic; they only raise the flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_reg   <= '0;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      err_reg     <= 1'b0;
      binary_reg  <= '0;
      err_out_reg <= 1'b0;
    end else if (load) begin
      shift_reg <= BCD_code;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else if (step) begin
      acc_reg   <= mac_result;
      err_reg   <= err_reg | digit_bad;
      shift_reg <= shift_reg << 4;
      cnt_reg   <= cnt_reg + CNT_W'(1);
      if (last_digit) begin
        binary_reg  <= mac_result;
        err_out_reg <= err_reg | digit_bad;
      end
    end
  end

  assign Binary_code = binary_reg;
  assign err         = err_out_reg;

endmodule

// File: tb/tb_bcd2b_ip.sv
// Directed and random checks for bcd2b_ip with a result scoreboard.
module tb_bcd2b_ip;

  localparam int DIGIT = 4;
  localparam int WIDTH = 14;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [DIGIT*4-1:0] BCD_code = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [WIDTH-1:0]   Binary_code;
  logic               err;

  int total = 0;
  int bad   = 0;
  int n_push = 0;
  int n_out  = 0;
  logic [WIDTH:0] exp_q[$];

  bcd2b_ip #(.DIGIT(DIGIT), .WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .BCD_code    (BCD_code),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .Binary_code (Binary_code),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: acc = acc*10 + nibble over the raw nibbles, MSD first.
  function automatic logic [WIDTH:0] ref_conv(input logic [DIGIT*4-1:0] w);
    int   acc;
    logic e;
    logic [3:0] nib;
    acc = 0;
    e   = 1'b0;
    for (int i = DIGIT - 1; i >= 0; i--) begin
      nib = w[4*i +: 4];
      acc = acc * 10 + int'(nib);
      if (nib > 4'd9) e = 1'b1;
    end
    return {e, WIDTH'(acc)};
  endfunction

  function automatic logic [DIGIT*4-1:0] to_bcd(input int n);
    logic [DIGIT*4-1:0] w;
    int v;
    v = n;
    w = '0;
    for (int i = 0; i < DIGIT; i++) begin
      w[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return w;
  endfunction

  always @(negedge clk) begin
    logic [WIDTH:0] e;
    if (rst_n && out_valid && out_ready) begin
      n_out++;
      check("out_not_extra", 32'(n_out <= n_push), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        $display("result %0d err=%0b expected %0d err=%0b", Binary_code, err, e[WIDTH-1:0], e[WIDTH]);
        check("result", 32'(Binary_code), 32'(e[WIDTH-1:0]));
        check("err", 32'(err), 32'(e[WIDTH]));
      end
    end
  end

  task automatic send(input logic [DIGIT*4-1:0] word, input bit push, input bit bp);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 300) begin
      @(posedge clk);
      #1;
      if (bp) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      waited++;
    end
    check("send_ready", 32'(in_ready), 32'd1);
    if (!in_ready) return;
    BCD_code = word;
    in_valid = 1'b1;
    @(posedge clk);
    if (push) begin
      exp_q.push_back(ref_conv(word));
      n_push++;
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_queue", 32'(exp_q.size()), 32'd0);
    check("drain_count", 32'(n_out), 32'(n_push));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int v;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_binary", 32'(Binary_code), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // 1234: latency and return to ready
    out_ready = 1'b1;
    send(16'h1234, 1'b1, 1'b0);
    @(negedge clk);
    repeat (3) @(negedge clk);
    check("lat_edge3_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_edge4_valid", 32'(out_valid), 32'd1);
    check("lat_edge4_value", 32'(Binary_code), 32'h04D2);
    @(negedge clk);
    check("lat_edge5_ready", 32'(in_ready), 32'd1);
    check("lat_edge5_valid", 32'(out_valid), 32'd0);

    // Back-to-back 9999 then 0000
    send(16'h9999, 1'b1, 1'b0);
    send(16'h0000, 1'b1, 1'b0);
    drain();

    // Invalid nibble
    send(16'h12A4, 1'b1, 1'b0);
    drain();

    // Output stall with ignored input pulses
    out_ready = 1'b0;
    send(16'h0500, 1'b1, 1'b0);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_value", 32'(Binary_code), 32'd500);
      check("stall_err", 32'(err), 32'd0);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      BCD_code = 16'h7777;
      in_valid = (i % 2 == 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("stall_release_valid", 32'(out_valid), 32'd0);
    check("stall_release_ready", 32'(in_ready), 32'd1);
    repeat (8) @(negedge clk);
    check("stall_no_extra", 32'(out_valid), 32'd0);
    check("stall_count", 32'(n_out), 32'(n_push));

    // Reset during conversion
    send(16'h8765, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_binary", 32'(Binary_code), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    repeat (10) @(negedge clk);
    check("abort_no_output", 32'(n_out), 32'(n_push));
    send(16'h0042, 1'b1, 1'b0);
    drain();

    // Random sweep with random backpressure
    for (int k = 0; k < 40; k++) begin
      v = int'($urandom_range(0, 9999));
      if (k == 0) v = 9999;
      if (k == 1) v = 0;
      send(to_bcd(v), 1'b1, 1'b1);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
